// File: rtl/mem_map_pkg.sv
// Game Boy CPU address map constants, decode regions and OAM DMA state encoding.
// Shared by the memory controller, the OAM DMA engine and the bench.
package mem_map_pkg;

  localparam logic [15:0] VramBase   = 16'h8000;
  localparam logic [15:0] VramLimit  = 16'h9FFF;
  localparam logic [15:0] OamBase    = 16'hFE00;
  localparam logic [15:0] OamLimit   = 16'hFE9F;
  localparam logic [15:0] HramBase   = 16'hFF80;
  localparam logic [15:0] JoypadReg  = 16'hFF00;
  localparam logic [15:0] TimerBase  = 16'hFF04;
  localparam logic [15:0] TimerLimit = 16'hFF07;
  localparam logic [15:0] IrqFlag    = 16'hFF0F;
  localparam logic [15:0] IrqEnable  = 16'hFFFF;
  localparam logic [15:0] SoundBase  = 16'hFF10;
  localparam logic [15:0] SoundLimit = 16'hFF3F;
  localparam logic [15:0] LcdBase    = 16'hFF40;
  localparam logic [15:0] LcdLimit   = 16'hFF4B;
  localparam logic [15:0] DmaReg     = 16'hFF46;
  localparam logic [15:0] BootReg    = 16'hFF50;

  typedef enum logic [1:0] {DmaIdle, DmaStart, DmaRead, DmaWrite} dma_state_e;

  typedef enum logic [3:0] {
    RegBoot, RegHram, RegDma, RegBootLatch, RegIrq, RegTimer,
    RegSound, RegJoypad, RegPpu, RegMain, RegNone
  } region_e;

  // Built-in boot image; synthesis flows substitute the file named by BOOT_ROM_FILE.
  function automatic logic [7:0] boot_rom_byte(logic [15:0] addr);
    return addr[7:0] ^ 8'hA5;
  endfunction

endpackage

// File: rtl/async_mem.sv
// Small RAM with synchronous write and combinational read; used for HRAM.
module async_mem #(
  parameter int unsigned DEPTH = 127,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {src,00} into FE00.. as READ/WRITE pairs.
module oam_dma
  import mem_map_pkg::*;
#(
  parameter int unsigned DMA_LEN = 160
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  start_src,
  input  logic [7:0]  mem_data,
  input  logic [7:0]  ppu_data,
  output logic        active,
  output logic        rd_req,
  output logic        wr_req,
  output logic        src_vram,
  output logic [15:0] src_addr,
  output logic [15:0] dst_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  src
);

  localparam int unsigned IdxW = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DMA_LEN - 1);

  dma_state_e      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0]      src_q, data_q, data_d, src_eff;

  // Echo RAM pages E0..FF alias C0..DF.
  assign src_eff  = (src_q >= 8'hE0) ? src_q - 8'h20 : src_q;
  assign src_addr = {src_eff, 8'h00} + 16'(idx_q);
  assign dst_addr = OamBase + 16'(idx_q);
  assign src_vram = (src_addr >= VramBase) && (src_addr <= VramLimit);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      DmaStart: state_d = DmaRead;
      DmaRead: begin
        data_d  = src_vram ? ppu_data : mem_data;
        state_d = DmaWrite;
      end
      DmaWrite: begin
        if (idx_q == LastIdx) begin
          state_d = DmaIdle;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = DmaRead;
        end
      end
      default: ;
    endcase
    // A new FF46 write overrides whatever the transfer was about to do.
    if (start) begin
      state_d = DmaStart;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DmaIdle;
      idx_q   <= '0;
      src_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      if (start) src_q <= start_src;
    end
  end

  assign active  = (state_q != DmaIdle);
  assign rd_req  = (state_q == DmaRead);
  assign wr_req  = (state_q == DmaWrite);
  assign wr_data = data_q;
  assign src     = src_q;

endmodule

// File: rtl/mem_ctrl_dma.sv
// Game Boy CPU memory controller with OAM DMA at FF46 and boot-ROM latch at FF50.
// Optional MEM_DMA_LOCKOUT_EN: CPU confined to HRAM/FF46/FF50 while DMA runs.
module mem_ctrl_dma
  import mem_map_pkg::*;
#(
  parameter int unsigned HRAM_DEPTH    = 127,
  parameter int unsigned DMA_LEN       = 160,
  parameter int unsigned BOOT_ROM_SIZE = 256,
  parameter              BOOT_ROM_FILE = "data/boot.rom"
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  output logic [7:0]  Do_cpu,
  input  logic        rd_cpu_n,
  input  logic        wr_cpu_n,
  output logic [15:0] A,
  output logic [7:0]  Do,
  input  logic [7:0]  Di,
  output logic        rd_n,
  output logic        wr_n,
  output logic        cs_n,
  output logic [15:0] A_ppu,
  output logic [7:0]  Do_ppu,
  input  logic [7:0]  Di_ppu,
  output logic        rd_ppu_n,
  output logic        wr_ppu_n,
  output logic        cs_ppu,
  input  logic [7:0]  Do_interrupt,
  input  logic [7:0]  Do_timer,
  input  logic [7:0]  Do_sound,
  input  logic [7:0]  Do_joypad,
  output logic        cs_interrupt,
  output logic        cs_timer,
  output logic        cs_sound,
  output logic        cs_joypad,
  output logic        dma_active
);

  localparam int unsigned HramAw = (HRAM_DEPTH > 1) ? $clog2(HRAM_DEPTH) : 1;

  region_e        region;
  logic           boot_en_q;
  logic [7:0]     hram_rdata, dma_src, dma_data;
  logic [15:0]    dma_src_addr, dma_dst_addr;
  logic           dma_rd, dma_wr, dma_vram, main_busy, ppu_busy, cpu_blocked;
  logic           unused_boot_file;

  assign unused_boot_file = ^BOOT_ROM_FILE;

  always_comb begin
    region = RegNone;
    if (boot_en_q && (32'(A_cpu) < BOOT_ROM_SIZE))                          region = RegBoot;
    else if (A_cpu >= HramBase && 32'(A_cpu) < 32'(HramBase) + HRAM_DEPTH) region = RegHram;
    else if (A_cpu == DmaReg)                                              region = RegDma;
    else if (A_cpu == BootReg)                                             region = RegBootLatch;
    else if (A_cpu == IrqFlag || A_cpu == IrqEnable)                       region = RegIrq;
    else if (A_cpu >= TimerBase && A_cpu <= TimerLimit)                    region = RegTimer;
    else if (A_cpu >= SoundBase && A_cpu <= SoundLimit)                    region = RegSound;
    else if (A_cpu == JoypadReg)                                           region = RegJoypad;
    else if ((A_cpu >= VramBase && A_cpu <= VramLimit) ||
             (A_cpu >= OamBase && A_cpu <= OamLimit) ||
             (A_cpu >= LcdBase && A_cpu <= LcdLimit))                      region = RegPpu;
    else if (A_cpu < OamBase)                                              region = RegMain;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      boot_en_q <= 1'b1;
    end else if (region == RegBootLatch && !wr_cpu_n && Di_cpu[0]) begin
      boot_en_q <= 1'b0;
    end
  end

  async_mem #(.DEPTH(HRAM_DEPTH), .WIDTH(8), .AW(HramAw)) u_hram (
    .clock (clock),
    .we    (region == RegHram && !wr_cpu_n),
    .addr  (HramAw'(A_cpu - HramBase)),
    .wdata (Di_cpu),
    .rdata (hram_rdata)
  );

  oam_dma #(.DMA_LEN(DMA_LEN)) u_dma (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (region == RegDma && !wr_cpu_n),
    .start_src (Di_cpu),
    .mem_data  (Di),
    .ppu_data  (Di_ppu),
    .active    (dma_active),
    .rd_req    (dma_rd),
    .wr_req    (dma_wr),
    .src_vram  (dma_vram),
    .src_addr  (dma_src_addr),
    .dst_addr  (dma_dst_addr),
    .wr_data   (dma_data),
    .src       (dma_src)
  );

  assign main_busy = dma_rd && !dma_vram;
  assign ppu_busy  = (dma_rd && dma_vram) || dma_wr;

  always_comb begin
    A            = A_cpu;
    Do           = Di_cpu;
    rd_n         = rd_cpu_n;
    wr_n         = wr_cpu_n;
    cs_n         = (region != RegMain);
    A_ppu        = A_cpu;
    Do_ppu       = Di_cpu;
    rd_ppu_n     = rd_cpu_n;
    wr_ppu_n     = wr_cpu_n;
    cs_ppu       = (region == RegPpu);
    cs_interrupt = (region == RegIrq);
    cs_timer     = (region == RegTimer);
    cs_sound     = (region == RegSound);
    cs_joypad    = (region == RegJoypad);
`ifdef MEM_DMA_LOCKOUT_EN
    cpu_blocked = dma_active && !(region inside {RegHram, RegDma, RegBootLatch});
    if (dma_active) begin
      {rd_n, wr_n, cs_n, rd_ppu_n, wr_ppu_n} = 5'b11111;
      {cs_ppu, cs_interrupt, cs_timer, cs_sound, cs_joypad} = 5'b00000;
    end
`else
    cpu_blocked = 1'b0;
`endif
    if (main_busy) begin
      A    = dma_src_addr;
      rd_n = 1'b0;
      wr_n = 1'b1;
      cs_n = 1'b0;
    end
    if (dma_rd && dma_vram) begin
      A_ppu    = dma_src_addr;
      rd_ppu_n = 1'b0;
      wr_ppu_n = 1'b1;
      cs_ppu   = 1'b1;
    end
    if (dma_wr) begin
      A_ppu    = dma_dst_addr;
      Do_ppu   = dma_data;
      rd_ppu_n = 1'b1;
      wr_ppu_n = 1'b0;
      cs_ppu   = 1'b1;
    end
  end

  always_comb begin
    Do_cpu = 8'hFF;
    case (region)
      RegBoot:      Do_cpu = boot_rom_byte(A_cpu);
      RegHram:      Do_cpu = hram_rdata;
      RegDma:       Do_cpu = dma_src;
      RegBootLatch: Do_cpu = {7'h7F, ~boot_en_q};
      RegIrq:       Do_cpu = Do_interrupt;
      RegTimer:     Do_cpu = Do_timer;
      RegSound:     Do_cpu = Do_sound;
      RegJoypad:    Do_cpu = Do_joypad;
      RegPpu:       Do_cpu = Di_ppu;
      RegMain:      Do_cpu = Di;
      default:      Do_cpu = 8'hFF;
    endcase
    // The port the DMA is using this cycle is not visible to the CPU.
    if (cpu_blocked || (main_busy && region == RegMain) || (ppu_busy && region == RegPpu)) begin
      Do_cpu = 8'hFF;
    end
  end

endmodule

// File: doc/mem_ctrl_dma.md
Name: mem_ctrl_dma

Overview:
- Second-generation CPU memory controller for the Game Boy core.
- Decodes the CPU address into chip selects for main memory (cartridge + WRAM), PPU, HRAM, boot ROM and the I/O blocks, and muxes read data back to the CPU.
- Adds an OAM DMA engine at FF46 and a readable FF50 boot-ROM latch.
- Parametrised in HRAM depth, DMA length and boot ROM size/file.

Parameters:
- HRAM_DEPTH, 127, bytes of high RAM mapped from FF80.
- DMA_LEN, 160, bytes copied per OAM DMA; destination is FE00..FE00+DMA_LEN-1.
- BOOT_ROM_SIZE, 256, boot ROM bytes mapped from 0000 while enabled.
- BOOT_ROM_FILE, "data/boot.rom", hex init file for the boot ROM.

Ports:
- clock in 1: system clock, all state on rising edge.
- reset_n in 1: asynchronous, active-low reset.
- A_cpu in 16: CPU address.
- Di_cpu in 8: CPU write data.
- Do_cpu out 8: read data to CPU.
- rd_cpu_n in 1: CPU read strobe, active low.
- wr_cpu_n in 1: CPU write strobe, active low.
- A out 16: main memory address.
- Do out 8: main memory write data.
- Di in 8: main memory read data, combinational.
- rd_n out 1: main memory read strobe, active low.
- wr_n out 1: main memory write strobe, active low.
- cs_n out 1: main memory select, active low.
- A_ppu out 16: PPU address.
- Do_ppu out 8: PPU write data.
- Di_ppu in 8: PPU read data, combinational.
- rd_ppu_n out 1: PPU read strobe, active low.
- wr_ppu_n out 1: PPU write strobe, active low.
- cs_ppu out 1: PPU select.
- Do_interrupt, Do_timer, Do_sound, Do_joypad in 8 each: I/O block read data.
- cs_interrupt, cs_timer, cs_sound, cs_joypad out 1 each: I/O block selects.
- dma_active out 1: high while an OAM DMA is in progress.

Behaviour:
- Reset (async, reset_n=0):
  - boot_en=1, dma_src=8'h00, dma_idx=0, FSM=IDLE, dma_active=0, dma_data=8'h00.
  - With A_cpu=0000 the outputs follow the decode below.
- Decode when FSM=IDLE: first match wins.
  - Boot ROM: boot_en && A<BOOT_ROM_SIZE.
  - HRAM: FF80..FF80+HRAM_DEPTH-1.
  - FF46 register.
  - FF50 register.
  - Interrupt: FF0F or FFFF.
  - Timer: FF04..FF07.
  - Sound: FF10..FF3F.
  - Joypad: FF00.
  - PPU: 8000-9FFF, FE00-FE9F, FF40-FF4B excluding FF46.
  - Main memory: A<FE00, cs_n=0.
  - Anything else reads 8'hFF.
- Register reads and writes:
  - FF46 reads dma_src.
  - FF50 reads {7'h7F, ~boot_en}.
  - A CPU write to FF50 with data bit0=1 clears boot_en on the clock edge. boot_en is set again only by reset.
- CPU pass-through: A, Do, rd_n, wr_n and the PPU equivalents mirror the CPU signals combinationally.
- DMA FSM, states IDLE, START, READ, WRITE:
  - A CPU write to FF46 on edge t: dma_src<=Di_cpu, dma_idx<=0, FSM<=START, dma_active=1 from t.
  - START, one cycle: -> READ.
  - READ, one cycle:
    - Source address = {src_eff, dma_idx}; src_eff = dma_src-8'h20 if dma_src>=8'hE0, else dma_src.
    - If the source is in 8000-9FFF: drive A_ppu, rd_ppu_n=0, cs_ppu=1, capture Di_ppu into dma_data.
    - Otherwise: drive A, rd_n=0, cs_n=0, capture Di.
    - -> WRITE.
  - WRITE, one cycle: A_ppu=FE00+dma_idx, Do_ppu=dma_data, wr_ppu_n=0, cs_ppu=1, main memory strobes inactive.
    - If dma_idx==DMA_LEN-1: -> IDLE, dma_active=0.
    - Otherwise dma_idx+1 -> READ.
  - Total: one FF46 write gives 1+2*DMA_LEN clocks of dma_active (321 at default).
- A CPU write to FF46 while DMA is active restarts the transfer: new dma_src, dma_idx=0, -> START. This takes priority over WRITE completion on the same edge.
- While dma_active, FF46/FF50/HRAM CPU accesses still function, including a restart write to FF46. Access to other regions is governed by the optional feature.
- reset_n asserted mid-DMA aborts immediately. OAM is left partially written.
- dma_idx width is clog2(DMA_LEN); the counter never wraps past DMA_LEN-1.

Optional Feature:
- Macro MEM_DMA_LOCKOUT_EN.
- Defined: while dma_active, CPU accesses outside HRAM/FF46/FF50 read 8'hFF, CPU writes there are suppressed, and all external strobes are owned by the DMA engine.
- Undefined: in START the CPU bus passes through. In READ/WRITE the DMA owns only the port it uses. The CPU keeps the other port, and CPU reads of the DMA-owned port return 8'hFF.

Decomposition:
- Package mem_map_pkg holds the region base/limit constants (VRAM, OAM, HRAM, IO ranges, FF46, FF50) and the DMA state enum.
- Sub-module oam_dma holds the FSM, dma_src, dma_idx and dma_data. It exposes a request/addr/strobe interface to the controller mux.
- HRAM reuses async_mem.

Test Plan:
- Reset, then read 0000 → Do_cpu=boot_rom[0]. Write 8'h01 to FF50, then read 0000 → Do_cpu=Di (main memory), and FF50 reads 8'hFF.
- Write 8'hC1 to FF46 with main memory returning data=addr[7:0] → 160 OAM writes FE00..FE9F with data 00..9F, dma_active high for exactly 321 clocks.
- Write 8'h80 to FF46 → reads use A_ppu 8000..809F and rd_ppu_n. Di is never sampled.
- Write 8'hE2 to FF46 → source reads at C200..C29F.
- Write 8'hC0 to FF46, then 8'hD0 at clock 50 → transfer restarts: first write after the restart is FE00 with data from D000, 321 clocks after the second write.
- Deassert reset_n mid-DMA → dma_active=0 immediately and FSM=IDLE. With MEM_DMA_LOCKOUT_EN defined, a CPU read of C000 during DMA returns 8'hFF, while a CPU read of FF80 returns HRAM data.
